// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, frame width and baud constants
package uart_pkg;

    localparam int DATA_BITS   = 8;
    localparam int CLK_FREQ_HZ = 100_000_000;
    localparam int BAUD_RATE   = 115_200;
    // Clocks per bit period produced by the external baud generator
    localparam int BAUD_PERIOD = CLK_FREQ_HZ / BAUD_RATE;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: one-entry holding register, shifter and frame FSM
module uart_tx
    import uart_pkg::*;
#(
    parameter logic [16:0] freq       = 17'(BAUD_RATE),
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0,
    parameter int          STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en,
    input  logic [7:0] d_in,
    input  logic       tx_start,
    input  logic       tx_count_baud_ready,
    output logic       tx_baud_en,
    output logic       d_out,
    output logic       tx_ready,
    output logic       busy,
    output logic       done
);

    if ((STOP_BITS != 1 && STOP_BITS != 2) || freq == 17'd0) begin : g_bad_cfg
        $error("uart_tx: STOP_BITS must be 1 or 2 and freq must be nonzero");
    end

    tx_state_t            state, state_next;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 hold_full_q, hold_full_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 parity_q, parity_d;
    logic                 d_out_d, done_d;
    logic                 tick, accept, launch, stop_last;

    assign tick       = tx_count_baud_ready;
    assign tx_ready   = ~hold_full_q;
    assign busy       = (state != IDLE);
    assign tx_baud_en = busy;
    assign accept     = tx_start & ~hold_full_q;
    assign stop_last  = (STOP_BITS == 2) ? stop_cnt_q : 1'b1;

    always_comb begin
        state_next  = state;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        stop_cnt_d  = stop_cnt_q;
        parity_d    = parity_q;
        d_out_d     = d_out;
        done_d      = 1'b0;
        launch      = 1'b0;

        if (accept) begin
            hold_d      = d_in;
            hold_full_d = 1'b1;
        end

        case (state)
            IDLE: launch = hold_full_q & tx_en;
            START: begin
                if (tick) begin
                    state_next = DATA;
                    d_out_d    = shift_q[0];
                    bit_cnt_d  = 3'd0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt_q == 3'd7) begin
                        if (PARITY_EN) begin
                            state_next = PARITY;
                            d_out_d    = parity_q;
                        end else begin
                            state_next = STOP;
                            d_out_d    = 1'b1;
                            stop_cnt_d = 1'b0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        d_out_d   = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_next = STOP;
                    d_out_d    = 1'b1;
                    stop_cnt_d = 1'b0;
                end
            end
            STOP: begin
                if (tick) begin
                    if (stop_last) begin
                        done_d = 1'b1;
                        // A waiting byte chains straight into its start bit
                        launch = hold_full_q & tx_en;
                        if (!launch) begin
                            state_next = IDLE;
                            d_out_d    = 1'b1;
                        end
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (launch) begin
            state_next  = START;
            shift_d     = hold_q;
            parity_d    = parity_of(hold_q, PARITY_ODD);
            hold_full_d = 1'b0;
            d_out_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= 3'd0;
            stop_cnt_q  <= 1'b0;
            parity_q    <= 1'b0;
            d_out       <= 1'b1;
            done        <= 1'b0;
        end else begin
            state       <= state_next;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            parity_q    <= parity_d;
            d_out       <= d_out_d;
            done        <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx with serial-frame scoreboard
module tb_uart_tx;

    localparam int PERIOD_FULL = 868;
    localparam int NDUT        = 3;
    localparam int NROWS       = 19;
    localparam int PE    [NDUT] = '{0, 1, 1};
    localparam int ODD   [NDUT] = '{0, 0, 1};
    localparam int STOPN [NDUT] = '{1, 2, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, tx_en, manual, man_tick;
    logic [7:0]      d_in;
    logic [NDUT-1:0] tx_start, tick, gen_tick, baud_en, d_out, tx_ready, busy, done;
    int              period;
    int              gen_cnt [NDUT];

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [NDUT][$];

    typedef struct {
        logic       rst, en, start, tick, push;
        logic [7:0] din;
        logic       ready, busy, dout, done, baud;
    } vec_t;
    vec_t tbl [NROWS];

    // Baud generator model: counts only while enabled, so each 0->1 restarts it
    always @(posedge clk)
        for (int i = 0; i < NDUT; i++)
            gen_cnt[i] <= (!baud_en[i] || gen_cnt[i] == period - 1) ? 0 : gen_cnt[i] + 1;

    always_comb begin
        gen_tick = '0;
        for (int i = 0; i < NDUT; i++)
            gen_tick[i] = baud_en[i] && (gen_cnt[i] == period - 1);
    end

    assign tick = {gen_tick[2:1], manual ? man_tick : gen_tick[0]};

    uart_tx dut0 (
        .clk(clk), .rst(rst), .tx_en(tx_en), .d_in(d_in), .tx_start(tx_start[0]),
        .tx_count_baud_ready(tick[0]), .tx_baud_en(baud_en[0]), .d_out(d_out[0]),
        .tx_ready(tx_ready[0]), .busy(busy[0]), .done(done[0])
    );

    uart_tx #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .tx_en(tx_en), .d_in(d_in), .tx_start(tx_start[1]),
        .tx_count_baud_ready(tick[1]), .tx_baud_en(baud_en[1]), .d_out(d_out[1]),
        .tx_ready(tx_ready[1]), .busy(busy[1]), .done(done[1])
    );

    uart_tx #(.PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(1)) dut2 (
        .clk(clk), .rst(rst), .tx_en(tx_en), .d_in(d_in), .tx_start(tx_start[2]),
        .tx_count_baud_ready(tick[2]), .tx_baud_en(baud_en[2]), .d_out(d_out[2]),
        .tx_ready(tx_ready[2]), .busy(busy[2]), .done(done[2])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int r, input int e, input int s, input int t, input int p,
                                input int din, input int rdy, input int bsy, input int dout,
                                input int dn, input int ben);
        vec_t v;
        v.rst = r[0]; v.en = e[0]; v.start = s[0]; v.tick = t[0]; v.push = p[0];
        v.din = din[7:0];
        v.ready = rdy[0]; v.busy = bsy[0]; v.dout = dout[0]; v.done = dn[0]; v.baud = ben[0];
        return v;
    endfunction

    task automatic send(input int i, input logic [7:0] b, input bit push);
        d_in = b;
        tx_start[i] = 1'b1;
        if (push) exp_q[i].push_back(b);
        @(posedge clk); #1;
        tx_start[i] = 1'b0;
    endtask

    task automatic wait_sig(input string name, input int i, input bit use_done, input logic lvl,
                            input int bound, output int n);
        n = 0;
        while (((use_done ? done[i] : d_out[i]) !== lvl) && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= bound) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout after %0d cycles", name, n);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Decodes frames by sampling d_out on each bit-ending tick, scoreboards them
    task automatic monitor();
        int         idx [NDUT];
        logic [7:0] got [NDUT];
        logic       par [NDUT];
        logic       done_exp [NDUT];
        logic [7:0] want;
        for (int i = 0; i < NDUT; i++) begin
            idx[i] = 0; got[i] = '0; par[i] = 1'b0; done_exp[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NDUT; i++) begin
                if (rst) begin
                    idx[i] = 0;
                    done_exp[i] = 1'b0;
                    exp_q[i].delete();
                end else begin
                    if (done_exp[i]) check($sformatf("done_pulse%0d", i), 32'(done[i]), 32'd1);
                    else if (done[i]) check($sformatf("spurious_done%0d", i), 32'(done[i]), 32'd0);
                    done_exp[i] = 1'b0;
                    if (tick[i] && baud_en[i]) begin
                        if (idx[i] == 0) check($sformatf("start_bit%0d", i), 32'(d_out[i]), 32'd0);
                        else if (idx[i] <= 8) got[i][idx[i]-1] = d_out[i];
                        else if (PE[i] != 0 && idx[i] == 9) par[i] = d_out[i];
                        else check($sformatf("stop_bit%0d", i), 32'(d_out[i]), 32'd1);
                        if (idx[i] == 8 + PE[i] + STOPN[i]) begin
                            if (exp_q[i].size() == 0) begin
                                checks++;
                                errors++;
                                $display("FAIL unexpected_frame%0d: got %0h required none", i, got[i]);
                            end else begin
                                want = exp_q[i].pop_front();
                                check($sformatf("frame_byte%0d", i), 32'(got[i]), 32'(want));
                                if (PE[i] != 0)
                                    check($sformatf("parity%0d", i), 32'(par[i]),
                                          32'((^want) ^ (ODD[i] != 0)));
                            end
                            idx[i] = 0;
                            done_exp[i] = 1'b1;
                        end else begin
                            idx[i]++;
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        int   n, c, t1, t2;
        logic lvl;
        bit   saw_busy;

        rst = 1'b1; tx_en = 1'b0; d_in = '0; tx_start = '0;
        manual = 1'b1; man_tick = 1'b0; period = PERIOD_FULL;
        fork
            monitor();
        join_none
        cycles(3);

        //              rst en st tk push din    rdy bsy dout done baud
        tbl[0]  = mk(1, 0, 0, 0, 0, 8'h00, 1, 0, 1, 0, 0);
        tbl[1]  = mk(0, 0, 1, 0, 1, 8'h81, 0, 0, 1, 0, 0);
        tbl[2]  = mk(0, 0, 1, 0, 0, 8'h42, 0, 0, 1, 0, 0);
        tbl[3]  = mk(0, 1, 0, 0, 0, 8'h00, 1, 1, 0, 0, 1);
        tbl[4]  = mk(0, 1, 0, 1, 0, 8'h00, 1, 1, 1, 0, 1);
        tbl[5]  = mk(0, 1, 1, 0, 1, 8'h18, 0, 1, 1, 0, 1);
        tbl[6]  = mk(0, 1, 0, 1, 0, 8'h00, 0, 1, 0, 0, 1);
        for (int r = 7; r <= 11; r++)
            tbl[r] = mk(0, 1, 0, 1, 0, 8'h00, 0, 1, 0, 0, 1);
        tbl[12] = mk(0, 1, 0, 1, 0, 8'h00, 0, 1, 1, 0, 1);
        tbl[13] = mk(0, 1, 0, 1, 0, 8'h00, 0, 1, 1, 0, 1);
        tbl[14] = mk(0, 1, 1, 1, 0, 8'h99, 1, 1, 0, 1, 1);
        tbl[15] = mk(0, 0, 0, 0, 0, 8'h00, 1, 1, 0, 0, 1);
        tbl[16] = mk(0, 0, 0, 1, 0, 8'h00, 1, 1, 0, 0, 1);
        tbl[17] = mk(1, 0, 0, 1, 0, 8'h00, 1, 0, 1, 0, 0);
        tbl[18] = mk(0, 1, 0, 0, 0, 8'h00, 1, 0, 1, 0, 0);

        for (int r = 0; r < NROWS; r++) begin
            rst = tbl[r].rst; tx_en = tbl[r].en; tx_start[0] = tbl[r].start;
            d_in = tbl[r].din; man_tick = tbl[r].tick;
            if (tbl[r].push) exp_q[0].push_back(tbl[r].din);
            @(posedge clk); #1;
            check($sformatf("row%0d_tx_ready", r), 32'(tx_ready[0]), 32'(tbl[r].ready));
            check($sformatf("row%0d_busy", r), 32'(busy[0]), 32'(tbl[r].busy));
            check($sformatf("row%0d_d_out", r), 32'(d_out[0]), 32'(tbl[r].dout));
            check($sformatf("row%0d_done", r), 32'(done[0]), 32'(tbl[r].done));
            check($sformatf("row%0d_baud_en", r), 32'(baud_en[0]), 32'(tbl[r].baud));
        end
        tx_start = '0; man_tick = 1'b0; manual = 1'b0; tx_en = 1'b1;
        cycles(2);

        // 0x55: alternating line, every bit exactly one baud period
        send(0, 8'h55, 1'b1);
        wait_sig("b_fall", 0, 1'b0, 1'b0, 4, n);
        check("b_start_latency", 32'(n), 32'd1);
        lvl = 1'b0;
        for (int k = 0; k < 9; k++) begin
            wait_sig($sformatf("b_seg%0d", k), 0, 1'b0, ~lvl, 2000, n);
            check($sformatf("b_seg%0d_len", k), 32'(n), 32'(PERIOD_FULL));
            lvl = ~lvl;
        end
        wait_sig("b_done", 0, 1'b1, 1'b1, 2000, n);
        check("b_stop_len", 32'(n), 32'(PERIOD_FULL));
        check("b_idle_busy", 32'(busy[0]), 32'd0);
        check("b_idle_d_out", 32'(d_out[0]), 32'd1);
        check("b_idle_baud_en", 32'(baud_en[0]), 32'd0);
        cycles(20);

        // 0xA5 then 0x3C while busy; 0xFF while holding is full must be dropped
        send(0, 8'hA5, 1'b1);
        cycles(2000);
        send(0, 8'h3C, 1'b1);
        check("c_ready_after_accept", 32'(tx_ready[0]), 32'd0);
        send(0, 8'hFF, 1'b0);
        check("c_ready_after_ignored", 32'(tx_ready[0]), 32'd0);
        wait_sig("c_done1", 0, 1'b1, 1'b1, 12000, n);
        check("c_b2b_d_out", 32'(d_out[0]), 32'd0);
        check("c_b2b_busy", 32'(busy[0]), 32'd1);
        check("c_b2b_baud_en", 32'(baud_en[0]), 32'd1);
        check("c_b2b_ready", 32'(tx_ready[0]), 32'd1);
        wait_sig("c_low_run", 0, 1'b0, 1'b1, 4000, n);
        check("c_3c_low_run", 32'(n), 32'(3 * PERIOD_FULL));
        wait_sig("c_done2", 0, 1'b1, 1'b1, 12000, n);
        check("c_end_busy", 32'(busy[0]), 32'd0);
        cycles(2000);
        check("c_no_third_frame", 32'(busy[0]), 32'd0);
        check("c_queue_empty", 32'(exp_q[0].size()), 32'd0);

        // Parity instances: 0x07 has odd weight
        d_in = 8'h07;
        tx_start[1] = 1'b1; tx_start[2] = 1'b1;
        exp_q[1].push_back(8'h07); exp_q[2].push_back(8'h07);
        @(posedge clk); #1;
        tx_start = '0;
        wait_sig("d_fall", 1, 1'b0, 1'b0, 4, n);
        check("d_start_latency", 32'(n), 32'd1);
        check("d_odd_start", 32'(d_out[2]), 32'd0);
        c = 0; t1 = -1; t2 = -1;
        while ((t1 < 0 || t2 < 0) && c < 15000) begin
            @(posedge clk); #1;
            c++;
            if (c == 9 * PERIOD_FULL + PERIOD_FULL / 2) begin
                check("d_parity_even", 32'(d_out[1]), 32'd1);
                check("d_parity_odd", 32'(d_out[2]), 32'd0);
            end
            if (c == 10 * PERIOD_FULL + 5 || c == 12 * PERIOD_FULL - 5)
                check($sformatf("d_stop2_high_at%0d", c), 32'(d_out[1]), 32'd1);
            if (done[1] && t1 < 0) t1 = c;
            if (done[2] && t2 < 0) t2 = c;
        end
        check("d_len_even_stop2", 32'(t1), 32'(12 * PERIOD_FULL));
        check("d_len_odd_stop1", 32'(t2), 32'(11 * PERIOD_FULL));
        cycles(20);

        // tx_en dropped mid-frame with a byte pending
        period = 100;
        send(0, 8'h5A, 1'b1);
        wait_sig("e_fall", 0, 1'b0, 1'b0, 4, n);
        cycles(450);
        tx_en = 1'b0;
        send(0, 8'hC3, 1'b1);
        check("e_pending_ready", 32'(tx_ready[0]), 32'd0);
        wait_sig("e_done", 0, 1'b1, 1'b1, 2000, n);
        check("e_stop_busy", 32'(busy[0]), 32'd0);
        check("e_stop_d_out", 32'(d_out[0]), 32'd1);
        cycles(300);
        check("e_held_busy", 32'(busy[0]), 32'd0);
        check("e_held_ready", 32'(tx_ready[0]), 32'd0);
        tx_en = 1'b1;
        @(posedge clk); #1;
        check("e_resume_d_out", 32'(d_out[0]), 32'd0);
        check("e_resume_busy", 32'(busy[0]), 32'd1);
        check("e_resume_ready", 32'(tx_ready[0]), 32'd1);
        wait_sig("e_done2", 0, 1'b1, 1'b1, 2000, n);
        cycles(20);

        // Reset during data bit 4 with a byte pending
        send(0, 8'h96, 1'b1);
        wait_sig("f_fall", 0, 1'b0, 1'b0, 4, n);
        cycles(300);
        send(0, 8'h11, 1'b1);
        cycles(249);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("f_rst_d_out", 32'(d_out[0]), 32'd1);
        check("f_rst_busy", 32'(busy[0]), 32'd0);
        check("f_rst_baud_en", 32'(baud_en[0]), 32'd0);
        check("f_rst_ready", 32'(tx_ready[0]), 32'd1);
        check("f_rst_done", 32'(done[0]), 32'd0);
        saw_busy = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            @(posedge clk); #1;
            if (busy[0]) saw_busy = 1'b1;
        end
        check("f_pending_discarded", 32'(saw_busy), 32'd0);

        for (int i = 0; i < NDUT; i++)
            check($sformatf("final_queue%0d", i), 32'(exp_q[i].size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
